// File: rtl/axis_decimator.sv
// AXI-Stream block-average decimator: averages N = 2^log2_ratio signed samples into one output.
// With enable low the block is a plain combinational wire from slave to master port.
//
//  state | meaning
//  ------+--------------------------------------------------
//  IDLE  | disabled or just reset; nothing accepted
//  ACCUM | collecting samples of the current block
//  HOLD  | averaged result waiting for downstream to take it
module axis_decimator #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int MAX_LOG2_RATIO   = 8
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        enable,
    input  logic [3:0]                  log2_ratio,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    localparam int W     = AXIS_TDATA_WIDTH;
    localparam int ACC_W = W + MAX_LOG2_RATIO;
    localparam int CNT_W = MAX_LOG2_RATIO + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [W-1:0]            avg;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_last;
    logic [3:0]              eff_ratio;
    logic [3:0]              ratio_clamped;
    logic [3:0]              ratio_cur;
    logic [W-1:0]            out_data;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    block_done;

    assign ratio_clamped = (log2_ratio > 4'(MAX_LOG2_RATIO)) ? 4'(MAX_LOG2_RATIO) : log2_ratio;
    // The first sample of a block already uses the live ratio, so N=1 completes on it.
    assign ratio_cur  = (cnt == '0) ? ratio_clamped : eff_ratio;
    assign cnt_last   = (CNT_W'(1) << ratio_cur) - CNT_W'(1);
    assign sum        = acc + {{MAX_LOG2_RATIO{S_AXIS_tdata[W-1]}}, S_AXIS_tdata};
    assign avg        = W'(sum >>> ratio_cur);

    assign in_xfer    = enable && S_AXIS_tvalid && S_AXIS_tready;
    assign out_xfer   = enable && M_AXIS_tvalid && M_AXIS_tready;
    assign block_done = in_xfer && (cnt == cnt_last);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ACCUM;
                ACCUM:   if (block_done) state_next = HOLD;
                HOLD:    if (out_xfer) state_next = block_done ? HOLD : ACCUM;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        S_AXIS_tready = M_AXIS_tready;
        M_AXIS_tvalid = S_AXIS_tvalid;
        M_AXIS_tdata  = S_AXIS_tdata;
        if (enable) begin
            M_AXIS_tdata  = out_data;
            M_AXIS_tvalid = (state == HOLD);
            case (state)
                ACCUM:   S_AXIS_tready = 1'b1;
                HOLD:    S_AXIS_tready = M_AXIS_tready;
                default: S_AXIS_tready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc       <= '0;
            cnt       <= '0;
            eff_ratio <= '0;
            out_data  <= '0;
        end else if (!enable) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            if (cnt == '0) begin
                eff_ratio <= ratio_clamped;
            end
            if (block_done) begin
                out_data <= avg;
                acc      <= '0;
                cnt      <= '0;
            end else if (in_xfer) begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_decimator.sv
// Directed and randomized bench for axis_decimator; a block-average reference model
// scores every output transfer, directed steps check latency, stalls, reset and bypass.
module tb_axis_decimator;

    localparam int W = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          enable;
    logic [3:0]    log2_ratio;
    logic          S_AXIS_tvalid;
    logic [W-1:0]  S_AXIS_tdata;
    logic          S_AXIS_tready;
    logic          M_AXIS_tready;
    logic          M_AXIS_tvalid;
    logic [W-1:0]  M_AXIS_tdata;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int m_sum   = 0;
    int m_cnt   = 0;
    int m_ratio = 0;

    always #5 aclk = ~aclk;

    axis_decimator #(.AXIS_TDATA_WIDTH(W), .MAX_LOG2_RATIO(8)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .log2_ratio    (log2_ratio),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tready (S_AXIS_tready),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tdata  (M_AXIS_tdata)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Mathematical floor of s / 2^r, computed by division rather than shifting.
    function automatic int avg_floor(input int s, input int r);
        int d;
        d = 1 << r;
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    function automatic int rnd16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    // Reference model: groups accepted samples into blocks of 2^ratio and scores outputs.
    initial begin
        forever begin
            @(negedge aclk);
            if (areset || !enable) begin
                m_sum = 0;
                m_cnt = 0;
                exp_q.delete();
            end else begin
                if (M_AXIS_tvalid && M_AXIS_tready) begin
                    chk("model_out_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) chk("model_out", $signed(M_AXIS_tdata), exp_q.pop_front());
                end
                if (S_AXIS_tvalid && S_AXIS_tready) begin
                    if (m_cnt == 0) m_ratio = (log2_ratio > 4'd8) ? 8 : int'(log2_ratio);
                    m_sum = m_sum + int'($signed(S_AXIS_tdata));
                    m_cnt++;
                    if (m_cnt == (1 << m_ratio)) begin
                        exp_q.push_back(avg_floor(m_sum, m_ratio));
                        m_sum = 0;
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int x);
        int t;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = 16'(x);
        t = 0;
        @(negedge aclk);
        while (!S_AXIS_tready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 50) chk("send_timeout", t, 0);
        tick();
    endtask

    task automatic wait_out(input string tag, input int exp);
        int t;
        t = 0;
        @(negedge aclk);
        while (!M_AXIS_tvalid && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk({tag, "_valid"}, M_AXIS_tvalid, 1);
        chk({tag, "_data"}, $signed(M_AXIS_tdata), exp);
        tick();
    endtask

    initial begin
        int v[12];
        int s;
        int x;
        areset        = 1'b1;
        enable        = 1'b1;
        log2_ratio    = 4'd2;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata  = '0;
        M_AXIS_tready = 1'b1;
        repeat (3) tick();

        @(negedge aclk);
        chk("rst_mvalid", M_AXIS_tvalid, 0);
        chk("rst_sready", S_AXIS_tready, 0);
        chk("rst_mdata", $signed(M_AXIS_tdata), 0);
        tick();
        areset = 1'b0;
        tick();

        // average of 4,8,-4,12 with one-cycle latency and a single output beat
        send(4); send(8); send(-4); send(12);
        S_AXIS_tvalid = 1'b0;
        @(negedge aclk);
        chk("r030_valid", M_AXIS_tvalid, 1);
        chk("r030_data", $signed(M_AXIS_tdata), 5);
        tick();
        @(negedge aclk);
        chk("r030_single", M_AXIS_tvalid, 0);
        tick();

        log2_ratio = 4'd1;
        send(-1); send(-2);
        S_AXIS_tvalid = 1'b0;
        wait_out("r031", -2);

        // N=1 at full throughput: one result per cycle, no bubbles
        log2_ratio = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            S_AXIS_tvalid = 1'b1;
            S_AXIS_tdata  = 16'(i);
            @(negedge aclk);
            chk("r032_sready", S_AXIS_tready, 1);
            if (i > 1) begin
                chk("r032_valid", M_AXIS_tvalid, 1);
                chk("r032_data", $signed(M_AXIS_tdata), i - 1);
            end
            tick();
        end
        S_AXIS_tvalid = 1'b0;
        @(negedge aclk);
        chk("r032_last_valid", M_AXIS_tvalid, 1);
        chk("r032_last_data", $signed(M_AXIS_tdata), 10);
        tick();

        // backpressure while a result is pending
        log2_ratio = 4'd2;
        send(10); send(20); send(30);
        M_AXIS_tready = 1'b0;
        send(40);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = 16'(100);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("r033_sready", S_AXIS_tready, 0);
            chk("r033_valid", M_AXIS_tvalid, 1);
            chk("r033_data", $signed(M_AXIS_tdata), 25);
            tick();
        end
        M_AXIS_tready = 1'b1;
        @(negedge aclk);
        chk("r033_release_sready", S_AXIS_tready, 1);
        tick();
        send(200); send(300); send(400);
        S_AXIS_tvalid = 1'b0;
        wait_out("r033_next", 250);

        // ratio change mid-block takes effect on the following block
        log2_ratio = 4'd2;
        for (int i = 0; i < 12; i++) v[i] = rnd16();
        send(v[0]); send(v[1]);
        log2_ratio = 4'd3;
        send(v[2]); send(v[3]);
        S_AXIS_tvalid = 1'b0;
        wait_out("r034_blk4", avg_floor(v[0] + v[1] + v[2] + v[3], 2));
        s = 0;
        for (int i = 4; i < 12; i++) begin
            send(v[i]);
            s = s + v[i];
        end
        S_AXIS_tvalid = 1'b0;
        wait_out("r034_blk8", avg_floor(s, 3));

        // reset after a partial block discards the partial sum
        log2_ratio = 4'd2;
        send(rnd16()); send(rnd16()); send(rnd16());
        S_AXIS_tvalid = 1'b0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("r035_rst_novalid", M_AXIS_tvalid, 0);
            tick();
        end
        s = 0;
        for (int i = 0; i < 4; i++) begin
            v[i] = rnd16();
            send(v[i]);
            s = s + v[i];
        end
        S_AXIS_tvalid = 1'b0;
        wait_out("r035_rst_avg", avg_floor(s, 2));

        // disable after a partial block, exercising bypass meanwhile
        send(rnd16()); send(rnd16()); send(rnd16());
        S_AXIS_tvalid = 1'b0;
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            x = rnd16();
            S_AXIS_tdata  = 16'(x);
            S_AXIS_tvalid = (k % 2 == 0);
            M_AXIS_tready = (k != 1);
            #1;
            chk("bypass_data", $signed(M_AXIS_tdata), x);
            chk("bypass_valid", M_AXIS_tvalid, (k % 2 == 0) ? 1 : 0);
            chk("bypass_ready", S_AXIS_tready, (k != 1) ? 1 : 0);
            tick();
        end
        S_AXIS_tvalid = 1'b0;
        M_AXIS_tready = 1'b1;
        enable = 1'b1;
        tick();
        s = 0;
        for (int i = 0; i < 4; i++) begin
            v[i] = rnd16();
            send(v[i]);
            s = s + v[i];
        end
        S_AXIS_tvalid = 1'b0;
        wait_out("r035_dis_avg", avg_floor(s, 2));

        @(negedge aclk);
        chk("model_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
